// File: rtl/cs_input_ctrl_if.sv
// cs_input_ctrl_if: cabinet control bundle between the raw inputs and cs_input_ctrl
//   joy_in[15:0], vsync : raw asynchronous inputs, driven by the master side
//   signal_cw/ccw/thrust/fire/start/coin, coin_pending[3:0], coin_drop : conditioned outputs, driven by the slave side
interface cs_input_ctrl_if;
  logic [15:0] joy_in;
  logic vsync;
  logic signal_ccw;
  logic signal_cw;
  logic signal_thrust;
  logic signal_fire;
  logic signal_start;
  logic signal_coin;
  logic [3:0] coin_pending;
  logic coin_drop;
  modport master(
    output joy_in, vsync,
    input signal_ccw, signal_cw, signal_thrust, signal_fire, signal_start, signal_coin, coin_pending, coin_drop
  );
  modport slave(
    input joy_in, vsync,
    output signal_ccw, signal_cw, signal_thrust, signal_fire, signal_start, signal_coin, coin_pending, coin_drop
  );
endinterface

// File: rtl/cs_input_ctrl.sv
// cs_input_ctrl: debounces cabinet controls, stretches start over a frame and paces queued coins
//   clk_sys : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : cs_input_ctrl_if.slave (joy_in/vsync in; signal_*, coin_pending, coin_drop out)
module cs_input_ctrl #(
  parameter int DEB_CYCLES = 50000,
  parameter int COIN_HIGH = 2500000,
  parameter int COIN_LOW = 2500000,
  parameter int QUEUE_MAX = 7
) (
  input logic clk_sys,
  input logic reset_n,
  cs_input_ctrl_if.slave bus
);
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int HW = (COIN_HIGH > 1) ? $clog2(COIN_HIGH) : 1;
  localparam int LW = (COIN_LOW > 1) ? $clog2(COIN_LOW) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HI_LAST = HW'(COIN_HIGH - 1);
  localparam logic [LW-1:0] LO_LAST = LW'(COIN_LOW - 1);
  localparam logic [3:0] Q_MAX = 4'(QUEUE_MAX);
  // bits 2 and 3 carry no control, so their debouncers stay parked at 0
  localparam logic [7:0] DEB_MASK = 8'b1111_0011;
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_HOLD} start_state_t;
  typedef enum logic [1:0] {C_IDLE, C_HIGH, C_LOW} coin_state_t;
  logic [7:0] r_joy_s1, r_joy_s2, r_deb;
  logic [7:0][DW-1:0] r_cnt;
  logic r_vs_s1, r_vs_s2, r_vs_d;
  logic r_start_d, r_coin_d, r_drop;
  logic [3:0] r_pending;
  logic [HW-1:0] r_hi_cnt;
  logic [LW-1:0] r_lo_cnt;
  start_state_t r_sstate, w_snext;
  coin_state_t r_cstate, w_cnext;
  logic w_vs_rise, w_start_rise, w_coin_rise, w_take, w_full, w_unused;
  assign w_unused = ^{bus.joy_in[15:8], r_joy_s2[3:2], r_deb[3:2]};
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      r_joy_s1 <= '0;
      r_joy_s2 <= '0;
      r_vs_s1 <= 1'b0;
      r_vs_s2 <= 1'b0;
      r_vs_d <= 1'b0;
      r_start_d <= 1'b0;
      r_coin_d <= 1'b0;
    end else begin
      r_joy_s1 <= bus.joy_in[7:0];
      r_joy_s2 <= r_joy_s1;
      r_vs_s1 <= bus.vsync;
      r_vs_s2 <= r_vs_s1;
      r_vs_d <= r_vs_s2;
      r_start_d <= r_deb[6];
      r_coin_d <= r_deb[7];
    end
  // counter runs only while the input disagrees with the debounced value
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      r_deb <= '0;
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (!DEB_MASK[i] || r_joy_s2[i] == r_deb[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == DEB_LAST) begin
          r_deb[i] <= r_joy_s2[i];
          r_cnt[i] <= '0;
        end else r_cnt[i] <= r_cnt[i] + DW'(1);
      end
    end
  assign w_vs_rise = r_vs_s2 & ~r_vs_d;
  assign w_start_rise = r_deb[6] & ~r_start_d;
  assign w_coin_rise = r_deb[7] & ~r_coin_d;
  assign w_take = (r_cstate == C_IDLE) && (r_pending != 4'd0);
  assign w_full = r_pending == Q_MAX;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) r_sstate <= S_IDLE;
    else r_sstate <= w_snext;
  always_comb begin
    w_snext = r_sstate;
    case (r_sstate)
      S_IDLE: w_snext = w_start_rise ? S_ARM : S_IDLE;
      S_ARM: w_snext = w_vs_rise ? S_HOLD : S_ARM;
      S_HOLD: w_snext = (w_vs_rise && !r_deb[6]) ? S_IDLE : S_HOLD;
      default: w_snext = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) r_cstate <= C_IDLE;
    else r_cstate <= w_cnext;
  always_comb begin
    w_cnext = r_cstate;
    case (r_cstate)
      C_IDLE: w_cnext = w_take ? C_HIGH : C_IDLE;
      C_HIGH: w_cnext = (r_hi_cnt == HI_LAST) ? C_LOW : C_HIGH;
      C_LOW: w_cnext = (r_lo_cnt == LO_LAST) ? C_IDLE : C_LOW;
      default: w_cnext = C_IDLE;
    endcase
  end
  // stage counters sit at 0 outside their state, so every entry starts from 0
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      r_hi_cnt <= '0;
      r_lo_cnt <= '0;
    end else begin
      r_hi_cnt <= (r_cstate == C_HIGH && r_hi_cnt != HI_LAST) ? r_hi_cnt + HW'(1) : '0;
      r_lo_cnt <= (r_cstate == C_LOW && r_lo_cnt != LO_LAST) ? r_lo_cnt + LW'(1) : '0;
    end
  // a coin arriving while one is taken cancels out, so a full queue never drops it
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      r_pending <= '0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_coin_rise & ~w_take & w_full;
      if (w_coin_rise && !w_take && !w_full) r_pending <= r_pending + 4'd1;
      else if (w_take && !w_coin_rise) r_pending <= r_pending - 4'd1;
    end
  assign bus.signal_cw = r_deb[0] & ~r_deb[1];
  assign bus.signal_ccw = r_deb[1] & ~r_deb[0];
  assign bus.signal_thrust = r_deb[4];
  assign bus.signal_fire = r_deb[5];
  assign bus.signal_start = r_sstate != S_IDLE;
  assign bus.signal_coin = r_cstate == C_HIGH;
  assign bus.coin_pending = r_pending;
  assign bus.coin_drop = r_drop;
endmodule

// File: tb/tb_cs_input_ctrl.sv
// tb_cs_input_ctrl: directed checks of debounce, direction interlock, start stretch, coin pacing and reset
module tb_cs_input_ctrl;
  logic clk_sys = 1'b0;
  logic reset_n;
  logic mon_en;
  logic [10:0] outs;
  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int drops, peak, rises, hi_min, hi_max, per_min, per_max, last_rise, hi_run;
  logic prev_coin;
  always #5 clk_sys = ~clk_sys;
  cs_input_ctrl_if ifc();
  cs_input_ctrl #(.DEB_CYCLES(4), .COIN_HIGH(8), .COIN_LOW(6), .QUEUE_MAX(3)) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus(ifc.slave)
  );
  assign outs = {ifc.signal_cw, ifc.signal_ccw, ifc.signal_thrust, ifc.signal_fire, ifc.signal_start,
                 ifc.signal_coin, ifc.coin_drop, ifc.coin_pending};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask
  task automatic press(input int b);
    ifc.joy_in[b] = 1'b1;
    tick(4);
    ifc.joy_in[b] = 1'b0;
    tick(4);
  endtask
  task automatic vs_pulse(input int hi, input int lo);
    ifc.vsync = 1'b1;
    tick(hi);
    ifc.vsync = 1'b0;
    tick(lo);
  endtask
  always @(negedge clk_sys) begin
    cyc++;
    if (!mon_en) begin
      drops = 0; peak = 0; rises = 0; hi_min = 999; hi_max = 0;
      per_min = 999; per_max = 0; last_rise = -1; hi_run = 0; prev_coin = 1'b0;
    end else begin
      if (ifc.coin_drop) drops++;
      if (int'(ifc.coin_pending) > peak) peak = int'(ifc.coin_pending);
      if (ifc.signal_coin) begin
        if (!prev_coin) begin
          rises++;
          if (last_rise >= 0) begin
            if (cyc - last_rise < per_min) per_min = cyc - last_rise;
            if (cyc - last_rise > per_max) per_max = cyc - last_rise;
          end
          last_rise = cyc;
          hi_run = 0;
        end
        hi_run++;
      end else if (prev_coin) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
      end
      prev_coin = ifc.signal_coin;
    end
  end
  initial begin
    reset_n = 1'b0;
    mon_en = 1'b0;
    ifc.vsync = 1'b0;
    ifc.joy_in = 16'hFF30;
    tick(3);
    chk("reset_outs", 32'(outs), 0);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("post_reset_quiet", 32'(outs), 0);
    end
    tick(1);
    chk("thrust_on", 32'(ifc.signal_thrust), 1);
    chk("fire_on", 32'(ifc.signal_fire), 1);
    chk("others_idle", 32'({ifc.signal_cw, ifc.signal_ccw, ifc.signal_start, ifc.signal_coin, ifc.coin_drop, ifc.coin_pending}), 0);
    ifc.joy_in = 16'hFF00;
    tick(6);
    chk("thrust_fire_off", 32'({ifc.signal_thrust, ifc.signal_fire}), 0);
    for (int i = 0; i < 40; i++) begin
      ifc.joy_in[0] = ~i[1];
      tick(1);
      chk("cw_bounce", 32'(ifc.signal_cw), 0);
    end
    ifc.joy_in[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("cw_settling", 32'(ifc.signal_cw), 0);
    end
    tick(1);
    chk("cw_on", 32'(ifc.signal_cw), 1);
    chk("ccw_off", 32'(ifc.signal_ccw), 0);
    ifc.joy_in = 16'h0000;
    tick(8);
    chk("cw_release", 32'(ifc.signal_cw), 0);
    ifc.joy_in[1:0] = 2'b11;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      chk("both_dirs", 32'({ifc.signal_cw, ifc.signal_ccw}), 0);
    end
    ifc.joy_in[0] = 1'b0;
    tick(5);
    chk("ccw_wait", 32'(ifc.signal_ccw), 0);
    tick(1);
    chk("ccw_on", 32'({ifc.signal_cw, ifc.signal_ccw}), 1);
    ifc.joy_in = 16'h0000;
    tick(8);
    ifc.joy_in[6] = 1'b1;
    tick(6);
    chk("start_not_yet", 32'(ifc.signal_start), 0);
    ifc.joy_in[6] = 1'b0;
    tick(1);
    chk("start_arm", 32'(ifc.signal_start), 1);
    tick(20);
    vs_pulse(10, 90);
    chk("start_after_vs1", 32'(ifc.signal_start), 1);
    ifc.vsync = 1'b1;
    tick(2);
    chk("start_vs2_sync", 32'(ifc.signal_start), 1);
    tick(1);
    chk("start_drop", 32'(ifc.signal_start), 0);
    ifc.vsync = 1'b0;
    tick(10);
    ifc.joy_in[6] = 1'b1;
    tick(7);
    chk("start_held_arm", 32'(ifc.signal_start), 1);
    vs_pulse(5, 15);
    vs_pulse(5, 15);
    chk("start_held_hold", 32'(ifc.signal_start), 1);
    ifc.joy_in[6] = 1'b0;
    tick(10);
    chk("start_released_wait", 32'(ifc.signal_start), 1);
    ifc.vsync = 1'b1;
    tick(3);
    chk("start_released_drop", 32'(ifc.signal_start), 0);
    ifc.vsync = 1'b0;
    tick(5);
    mon_en = 1'b1;
    tick(2);
    for (int k = 0; k < 8; k++) press(7);
    tick(60);
    chk("coin_drops", 32'(drops), 1);
    chk("coin_peak", 32'(peak), 3);
    chk("coin_pulses", 32'(rises), 7);
    chk("coin_hi_min", 32'(hi_min), 8);
    chk("coin_hi_max", 32'(hi_max), 8);
    chk("coin_per_min", 32'(per_min), 15);
    chk("coin_per_max", 32'(per_max), 15);
    chk("coin_drained", 32'({ifc.signal_coin, ifc.coin_pending}), 0);
    mon_en = 1'b0;
    tick(2);
    mon_en = 1'b1;
    tick(1);
    for (int k = 0; k < 5; k++) press(7);
    chk("rst_pulses_before", 32'(rises), 3);
    chk("rst_coin_high", 32'(ifc.signal_coin), 1);
    chk("rst_pending_before", 32'(ifc.coin_pending), 2);
    reset_n = 1'b0;
    #1;
    chk("rst_coin_now", 32'(ifc.signal_coin), 0);
    chk("rst_pending_now", 32'(ifc.coin_pending), 0);
    chk("rst_outs_now", 32'(outs), 0);
    tick(3);
    reset_n = 1'b1;
    tick(40);
    chk("rst_no_more_pulses", 32'(rises), 3);
    chk("rst_idle_after", 32'(outs), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
